// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg : shared constants and FSM encoding for dmem_arbiter.
// Optional read-modify-write support is enabled by DMEM_RMW_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic        RD_ENABLE  = 1'b1;
    localparam logic        WR_ENABLE  = 1'b1;
    localparam logic        RST_ENABLE = 1'b1;

`ifdef DMEM_RMW_EN
    localparam logic [3:0]  BE_FULL    = 4'hF;
    localparam logic [3:0]  BE_NONE    = 4'h0;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    // Expand byte enables into a per-bit mask.
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction
`else
    typedef enum logic [0:0] {
        IDLE = 1'b0
    } state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2 : two-way round-robin selector; the port not granted last wins ties.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic       any,
    output logic       sel
);
    import dmem_arbiter_pkg::*;

    logic last;

    // Pointer starts at port 1 so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            last <= 1'b1;
        end else if (upd) begin
            last <= upd_id;
        end
    end

    assign any = |req;
    assign sel = req[1] & (~req[0] | ~last);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arbiter : two-master data-memory arbiter with single-cycle access.
// Define DMEM_RMW_EN to merge partial writes through a read-modify-write pass.
// Revision: 1.0
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_be,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_be,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_cre_o,
    output logic              ram_cwe_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);
    import dmem_arbiter_pkg::*;

    logic              live;
    logic              active;
    logic              req_any;
    logic              arb_sel;
    logic              owner;
    logic              grant;
    logic              rd_grant;
    logic              own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              cre;
    logic              cwe;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    // Requests seen while reset is asserted are masked out entirely.
    assign live = (rst != RST_ENABLE);

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    ({m1_req & live, m0_req & live}),
        .upd    (grant),
        .upd_id (owner),
        .any    (req_any),
        .sel    (arb_sel)
    );

`ifdef DMEM_RMW_EN
    state_t            state;
    logic              rmw_owner;
    logic [DATA_W-1:0] rmw_word;
    logic              rmw_start;
    logic [3:0]        own_be;
    logic [DATA_W-1:0] merged;

    assign owner  = (state == RMW_WR) ? rmw_owner : arb_sel;
    assign active = live & (req_any | (state == RMW_WR));
    assign own_be = owner ? m1_be : m0_be;
    assign merged = (own_wdata & be_mask(own_be)) | (rmw_word & ~be_mask(own_be));
`else
    logic unused_be;
    assign unused_be = ^{m0_be, m1_be};
    assign owner     = arb_sel;
    assign active    = live & req_any;
`endif

    assign own_we    = owner ? m1_we    : m0_we;
    assign own_addr  = owner ? m1_addr  : m0_addr;
    assign own_wdata = owner ? m1_wdata : m0_wdata;

    always_comb begin
        cre       = ~RD_ENABLE;
        cwe       = ~WR_ENABLE;
        addr_mux  = '0;
        wdata_mux = ZERO_WORD;
        grant     = 1'b0;
`ifdef DMEM_RMW_EN
        rmw_start = 1'b0;
`endif
        if (active) begin
            addr_mux = own_addr;
`ifdef DMEM_RMW_EN
            if (state == RMW_WR) begin
                cwe       = WR_ENABLE;
                wdata_mux = merged;
                grant     = 1'b1;
            end else if (!own_we) begin
                cre   = RD_ENABLE;
                grant = 1'b1;
            end else if (own_be == BE_FULL) begin
                cwe       = WR_ENABLE;
                wdata_mux = own_wdata;
                grant     = 1'b1;
            end else if (own_be == BE_NONE) begin
                grant = 1'b1;
            end else begin
                // Partial write: fetch the old word now, write the merge next cycle.
                cre       = RD_ENABLE;
                rmw_start = 1'b1;
            end
`else
            if (!own_we) begin
                cre   = RD_ENABLE;
                grant = 1'b1;
            end else begin
                cwe       = WR_ENABLE;
                wdata_mux = own_wdata;
                grant     = 1'b1;
            end
`endif
        end
    end

`ifdef DMEM_RMW_EN
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state     <= IDLE;
            rmw_owner <= 1'b0;
            rmw_word  <= ZERO_WORD;
        end else begin
            case (state)
                IDLE: begin
                    if (rmw_start) begin
                        state     <= RMW_WR;
                        rmw_owner <= owner;
                        rmw_word  <= ram_rdata_i;
                    end
                end
                RMW_WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`endif

    assign rd_grant = grant & ~own_we;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= ZERO_WORD;
            rdata1_q  <= ZERO_WORD;
        end else begin
            rvalid0_q <= rd_grant & ~owner;
            rvalid1_q <= rd_grant & owner;
            if (rd_grant && !owner) begin
                rdata0_q <= ram_rdata_i;
            end
            if (rd_grant && owner) begin
                rdata1_q <= ram_rdata_i;
            end
        end
    end

    assign m0_gnt      = grant & ~owner;
    assign m1_gnt      = grant & owner;
    assign m0_rvalid   = live & rvalid0_q;
    assign m1_rvalid   = live & rvalid1_q;
    assign m0_rdata    = live ? rdata0_q : ZERO_WORD;
    assign m1_rdata    = live ? rdata1_q : ZERO_WORD;
    assign ram_cre_o   = cre;
    assign ram_cwe_o   = cwe;
    assign ram_addr_o  = addr_mux;
    assign ram_wdata_o = wdata_mux;

endmodule
`default_nettype wire
